// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and IDLE/RUN/HALTED control.
// Program memory is read combinationally from pm_addr in the same cycle.
module fetch_unit #(
    parameter int                 PC_W      = 4,
    parameter int                 INSTR_W   = 9,
    parameter logic [INSTR_W-1:0] NOP_CODE  = 9'b000000000,
    parameter logic [INSTR_W-1:0] HALT_CODE = 9'b111111111
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [PC_W-1:0]    pm_addr,
    input  logic [INSTR_W-1:0] pm_instr,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               if_valid,
    output logic               running,
    output logic               halted,
    output logic [7:0]         fetch_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [PC_W-1:0]    pc_p0, pc_nx;
    logic [INSTR_W-1:0] instr_p1, instr_nx;
    logic [PC_W-1:0]    ipc_p1, ipc_nx;
    logic               vld_p1, vld_nx;
    logic [7:0]         cnt, cnt_nx;
    logic               running_r, halted_r;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Next-state and next-register decode; priority in RUN is redirect, stall, halt, fetch
    always_comb begin
        state_nx = state;
        pc_nx    = pc_p0;
        instr_nx = instr_p1;
        ipc_nx   = ipc_p1;
        vld_nx   = vld_p1;
        cnt_nx   = cnt;
        case (state)
            ST_IDLE: begin
                pc_nx    = '0;
                instr_nx = NOP_CODE;
                ipc_nx   = '0;
                vld_nx   = 1'b0;
                if (start) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_nx    = redirect_pc;
                    instr_nx = NOP_CODE;
                    ipc_nx   = '0;
                    vld_nx   = 1'b0;
                end else if (stall) begin
                    pc_nx = pc_p0;
                end else if (pm_instr == HALT_CODE) begin
                    instr_nx = HALT_CODE;
                    ipc_nx   = pc_p0;
                    vld_nx   = 1'b1;
                    cnt_nx   = sat_inc(cnt);
                    state_nx = ST_HALTED;
                end else begin
                    instr_nx = pm_instr;
                    ipc_nx   = pc_p0;
                    vld_nx   = 1'b1;
                    pc_nx    = pc_p0 + PC_W'(1);
                    cnt_nx   = sat_inc(cnt);
                end
            end
            ST_HALTED: begin
                instr_nx = NOP_CODE;
                ipc_nx   = '0;
                vld_nx   = 1'b0;
                if (start) begin
                    pc_nx    = '0;
                    cnt_nx   = '0;
                    state_nx = ST_RUN;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                pc_nx    = '0;
                instr_nx = NOP_CODE;
                ipc_nx   = '0;
                vld_nx   = 1'b0;
            end
        endcase
    end

    // p0 -> p1: PC and IF/ID register; running/halted lag the state register by one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc_p0     <= '0;
            instr_p1  <= NOP_CODE;
            ipc_p1    <= '0;
            vld_p1    <= 1'b0;
            cnt       <= '0;
            running_r <= 1'b0;
            halted_r  <= 1'b0;
        end else begin
            state     <= state_nx;
            pc_p0     <= pc_nx;
            instr_p1  <= instr_nx;
            ipc_p1    <= ipc_nx;
            vld_p1    <= vld_nx;
            cnt       <= cnt_nx;
            running_r <= (state == ST_RUN);
            halted_r  <= (state == ST_HALTED);
        end
    end

    assign pm_addr   = pc_p0;
    assign if_instr  = instr_p1;
    assign if_pc     = ipc_p1;
    assign if_valid  = vld_p1;
    assign running   = running_r;
    assign halted    = halted_r;
    assign fetch_cnt = cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected outputs per edge, monitor pops and compares.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       redirect = 1'b0;
    logic [3:0] redirect_pc = '0;
    logic [3:0] pm_addr;
    logic [8:0] pm_instr;
    logic [8:0] if_instr;
    logic [3:0] if_pc;
    logic       if_valid;
    logic       running;
    logic       halted;
    logic [7:0] fetch_cnt;

    logic [8:0] mem [16];

    fetch_unit #(
        .PC_W(4), .INSTR_W(9), .NOP_CODE(9'h000), .HALT_CODE(9'h1FF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .pm_addr(pm_addr), .pm_instr(pm_instr),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .running(running), .halted(halted), .fetch_cnt(fetch_cnt)
    );

    assign pm_instr = mem[pm_addr];

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] addr;
        logic [8:0] instr;
        logic [3:0] ipc;
        logic       vld;
        logic       run;
        logic       hlt;
        logic [7:0] cnt;
    } obs_t;

    obs_t act;
    assign act = {pm_addr, if_instr, if_pc, if_valid, running, halted, fetch_cnt};

    obs_t exp_q[$];
    int   id_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step_id = 0;

    task automatic compare(input int id, input obs_t e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL step %0d: got addr=%0d instr=%h pc=%0d vld=%b run=%b hlt=%b cnt=%0d, want addr=%0d instr=%h pc=%0d vld=%b run=%b hlt=%b cnt=%0d",
                     id, act.addr, act.instr, act.ipc, act.vld, act.run, act.hlt, act.cnt,
                     e.addr, e.instr, e.ipc, e.vld, e.run, e.hlt, e.cnt);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the following edge
    task automatic step(input logic st, input logic sl, input logic rd, input logic [3:0] rp,
                        input logic [3:0] a, input logic [8:0] i, input logic [3:0] p,
                        input logic v, input logic r, input logic h, input logic [7:0] c);
        @(negedge clk);
        start       = st;
        stall       = sl;
        redirect    = rd;
        redirect_pc = rp;
        step_id++;
        exp_q.push_back(obs_t'({a, i, p, v, r, h, c}));
        id_q.push_back(step_id);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        obs_t e;
        int   id;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            compare(id, e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want summary before 100000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t zero;
        zero = '0;
        for (int k = 0; k < 16; k++) mem[k] = 9'h155;
        mem[0] = 9'h011; mem[1] = 9'h022; mem[2] = 9'h033; mem[3] = 9'h1FF;

        // Power-on reset with garbage on pm_instr
        #1 rst_n = 1'b0;
        #2 compare(-1, zero);
        @(negedge clk) rst_n = 1'b1;
        step(0, 0, 0, 0, 4'd0, 9'h000, 4'd0, 0, 0, 0, 8'd0);

        // Short program ending in HALT_CODE
        step(1, 0, 0, 0, 4'd0, 9'h000, 4'd0, 0, 0, 0, 8'd0);
        step(0, 0, 0, 0, 4'd1, 9'h011, 4'd0, 1, 1, 0, 8'd1);
        step(0, 0, 0, 0, 4'd2, 9'h022, 4'd1, 1, 1, 0, 8'd2);
        step(0, 0, 0, 0, 4'd3, 9'h033, 4'd2, 1, 1, 0, 8'd3);
        step(0, 0, 0, 0, 4'd3, 9'h1FF, 4'd3, 1, 1, 0, 8'd4);
        step(0, 0, 0, 0, 4'd3, 9'h000, 4'd0, 0, 0, 1, 8'd4);
        step(0, 1, 1, 4'd7, 4'd3, 9'h000, 4'd0, 0, 0, 1, 8'd4);
        step(1, 0, 0, 0, 4'd0, 9'h000, 4'd0, 0, 0, 1, 8'd0);
        step(0, 0, 0, 0, 4'd1, 9'h011, 4'd0, 1, 1, 0, 8'd1);
        step(0, 0, 0, 0, 4'd2, 9'h022, 4'd1, 1, 1, 0, 8'd2);
        step(0, 0, 0, 0, 4'd3, 9'h033, 4'd2, 1, 1, 0, 8'd3);
        step(0, 0, 0, 0, 4'd3, 9'h1FF, 4'd3, 1, 1, 0, 8'd4);
        step(0, 0, 0, 0, 4'd3, 9'h000, 4'd0, 0, 0, 1, 8'd4);

        // Program without HALT_CODE: 040..04F
        for (int k = 0; k < 16; k++) mem[k] = 9'h040 + 9'(k);
        step(1, 0, 0, 0, 4'd0, 9'h000, 4'd0, 0, 0, 1, 8'd0);
        step(0, 0, 0, 0, 4'd1, 9'h040, 4'd0, 1, 1, 0, 8'd1);
        step(0, 0, 0, 0, 4'd2, 9'h041, 4'd1, 1, 1, 0, 8'd2);
        step(0, 0, 0, 0, 4'd3, 9'h042, 4'd2, 1, 1, 0, 8'd3);
        step(0, 1, 0, 0, 4'd3, 9'h042, 4'd2, 1, 1, 0, 8'd3);
        step(0, 1, 0, 0, 4'd3, 9'h042, 4'd2, 1, 1, 0, 8'd3);
        step(0, 1, 0, 0, 4'd3, 9'h042, 4'd2, 1, 1, 0, 8'd3);
        step(1, 0, 0, 0, 4'd4, 9'h043, 4'd3, 1, 1, 0, 8'd4);
        step(0, 1, 1, 4'd9, 4'd9, 9'h000, 4'd0, 0, 1, 0, 8'd4);
        step(0, 0, 0, 0, 4'd10, 9'h049, 4'd9, 1, 1, 0, 8'd5);
        step(0, 0, 0, 0, 4'd11, 9'h04A, 4'd10, 1, 1, 0, 8'd6);
        step(0, 0, 0, 0, 4'd12, 9'h04B, 4'd11, 1, 1, 0, 8'd7);
        step(0, 0, 0, 0, 4'd13, 9'h04C, 4'd12, 1, 1, 0, 8'd8);
        step(0, 0, 0, 0, 4'd14, 9'h04D, 4'd13, 1, 1, 0, 8'd9);
        step(0, 0, 0, 0, 4'd15, 9'h04E, 4'd14, 1, 1, 0, 8'd10);
        step(0, 0, 0, 0, 4'd0, 9'h04F, 4'd15, 1, 1, 0, 8'd11);
        step(0, 0, 0, 0, 4'd1, 9'h040, 4'd0, 1, 1, 0, 8'd12);

        // Asynchronous reset pulse between edges while running
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 compare(-2, zero);
        #1 rst_n = 1'b1;
        #1 compare(-3, zero);
        step(0, 0, 0, 0, 4'd0, 9'h000, 4'd0, 0, 0, 0, 8'd0);
        step(0, 0, 0, 0, 4'd0, 9'h000, 4'd0, 0, 0, 0, 8'd0);

        // Long run: address wrap and fetch_cnt saturation
        step(1, 0, 0, 0, 4'd0, 9'h000, 4'd0, 0, 0, 0, 8'd0);
        for (int k = 1; k <= 260; k++) begin
            step(0, 0, 0, 0, 4'(k % 16), 9'h040 + 9'((k - 1) % 16), 4'((k - 1) % 16),
                 1, 1, 0, (k > 255) ? 8'd255 : 8'(k));
        end

        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
